// File: rtl/posit_div_seq_pkg.sv
// Shared definitions for the posit<32,2> sequential divider.
//   - Width constants (NBITS, ES, FHBITS, FBITS, QBITS) and the NaR pattern.
//   - FSM state encoding (div_state_t) as plain 2-bit constants.
//   - posit_value_t: decoded operand; value_quotient: input bundle of the packer.
//   - posit_extract(): posit -> {sign, scale, fraction, inf, zero}.
package posit_div_seq_pkg;

  localparam int NBITS  = 32;
  localparam int ES     = 2;
  localparam int FHBITS = NBITS - ES;   // hidden bit + fraction field
  localparam int FBITS  = FHBITS - 1;   // fraction field, left aligned
  localparam int QBITS  = FHBITS + 2;   // quotient bits, one per DIVIDE cycle

  localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

  typedef logic [1:0] div_state_t;
  localparam div_state_t IDLE       = 2'd0;
  localparam div_state_t DIVIDE     = 2'd1;
  localparam div_state_t NORM_ROUND = 2'd2;
  localparam div_state_t DONE       = 2'd3;

  // scale is a two's complement value of regime*2^ES + exponent
  typedef struct packed {
    logic             sgn;
    logic [8:0]       scale;
    logic [FBITS-1:0] fraction;
    logic             inf;
    logic             zero;
  } posit_value_t;

  typedef struct packed {
    logic             sgn;
    logic [8:0]       scale;
    logic [QBITS-2:0] fraction;   // bits below the hidden one
    logic             sticky;
    logic             inf;
    logic             zero;
  } value_quotient;

  function automatic posit_value_t posit_extract(input logic [NBITS-1:0] x);
    posit_value_t     v;
    logic [NBITS-2:0] body;
    logic [NBITS-2:0] rest;
    logic [5:0]       run;
    logic             stop;
    logic [ES-1:0]    expo;
    v      = '0;
    v.sgn  = x[NBITS-1];
    v.zero = (x == '0);
    v.inf  = (x == NAR);
    // Magnitude: two's complement of the low bits when negative.
    body = x[NBITS-1] ? (~x[NBITS-2:0] + (NBITS-1)'(1)) : x[NBITS-2:0];
    // Length of the regime run (identical bits starting at the MSB).
    run  = 6'd1;
    stop = 1'b0;
    for (int i = NBITS - 3; i >= 0; i--) begin
      if (!stop && body[i] == body[NBITS-2]) run = run + 6'd1;
      else stop = 1'b1;
    end
    // Drop the run and its terminator; exponent then fraction follow.
    rest       = body << (run + 6'd1);
    expo       = rest[NBITS-2 -: ES];
    v.fraction = rest[FBITS-1:0];
    if (body[NBITS-2]) v.scale = {1'b0, run - 6'd1, expo};
    else               v.scale = 9'd0 - {1'b0, run, 2'b00} + {7'd0, expo};
    return v;
  endfunction

endpackage

// File: rtl/posit_div_seq_if.sv
// Request/response bundle of the posit divider.
//   master: start, in1 (dividend), in2 (divisor) out; result, inf, zero, done, busy in.
//   slave : the reverse, used by the divider itself.
interface posit_div_seq_if;
  import posit_div_seq_pkg::*;

  logic             start;
  logic [NBITS-1:0] in1;
  logic [NBITS-1:0] in2;
  logic [NBITS-1:0] result;
  logic             inf;
  logic             zero;
  logic             done;
  logic             busy;

  modport master (output start, in1, in2, input result, inf, zero, done, busy);
  modport slave  (input start, in1, in2, output result, inf, zero, done, busy);
endinterface

// File: rtl/posit_div_seq_round_pack.sv
// Combinational posit packer: sign, scale, fraction, sticky -> 32-bit posit.
//   vq    : value to encode (inf/zero flags force NaR/zero).
//   posit : encoded result, round to nearest even, saturating at
//           maxpos/minpos so a finite nonzero value never becomes 0 or NaR.
module posit_div_seq_round_pack
  import posit_div_seq_pkg::*;
(
  input  value_quotient    vq,
  output logic [NBITS-1:0] posit
);

  localparam logic signed [8:0] MAX_SCALE = 9'sd120;

  logic signed [6:0] regime;
  logic [ES-1:0]     expo;
  logic [6:0]        shamt;
  logic [71:0]       pat;
  logic [71:0]       shifted;
  logic [NBITS-2:0]  body;
  logic [NBITS-2:0]  mag;
  logic              guard;
  logic              sticky_all;
  logic              round_up;

  // NOTE: every variable gets a value at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    posit  = '0;
    mag    = '0;
    regime = 7'($signed(vq.scale) >>> ES);
    expo   = vq.scale[ES-1:0];
    // Seed "10" (positive regime) or "01" (negative) and sign-extend it
    // by the run length; ~regime equals -regime-1 for negative regimes.
    shamt   = regime[6] ? ~regime : regime;
    pat     = {regime[6] ? 2'b01 : 2'b10, expo, vq.fraction, 37'd0};
    shifted = $signed(pat) >>> shamt;
    body       = shifted[71:41];
    guard      = shifted[40];
    sticky_all = (|shifted[39:0]) | vq.sticky;
    round_up   = guard & (body[0] | sticky_all);
    if (vq.inf) begin
      posit = NAR;
    end else if (vq.zero) begin
      posit = '0;
    end else begin
      if ($signed(vq.scale) > MAX_SCALE)       mag = '1;
      else if ($signed(vq.scale) < -MAX_SCALE) mag = (NBITS-1)'(1);
      else                                     mag = body + (NBITS-1)'(round_up);
      posit = vq.sgn ? {1'b1, ~mag + (NBITS-1)'(1)} : {1'b0, mag};
    end
  end

endmodule

// File: rtl/posit_div_seq.sv
// Iterative posit<32,2> divider, result = in1 / in2.
//   clk   : clock, rising edge.
//   reset : synchronous, active high; aborts any division in flight.
//   bus   : slave side of posit_div_seq_if (start/in1/in2 in,
//           result/inf/zero/done/busy out).
// One restoring quotient bit per DIVIDE cycle, then one NORM_ROUND cycle;
// done pulses one cycle after that. NaR/zero operands finish in one cycle.
// Build option: POSIT_DIV_EARLY_TERM_EN ends DIVIDE as soon as the
// remainder is exactly zero (same result bits, shorter latency).
module posit_div_seq
  import posit_div_seq_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  posit_div_seq_if.slave bus
);

  div_state_t        state;
  posit_value_t      a;
  posit_value_t      b;
  logic              sign_q;
  logic signed [8:0] scale_q;
  logic [FHBITS:0]   rem;        // one spare bit: rem < 2*div between steps
  logic [FHBITS-1:0] div;
  logic [QBITS-1:0]  q;
  logic [5:0]        cnt;
  logic              ge;
  logic [FHBITS:0]   rem_next;
  logic [QBITS-1:0]  q_next;
  value_quotient     vq;
  logic [NBITS-1:0]  packed_q;

  assign a = posit_extract(bus.in1);
  assign b = posit_extract(bus.in2);

  assign ge       = (rem >= {1'b0, div});
  assign rem_next = ge ? ((rem - {1'b0, div}) << 1) : (rem << 1);
  assign q_next   = {q[QBITS-2:0], ge};

  // Quotient of two [1,2) significands lies in (0.5,2): at most one
  // normalising shift. The bit shifted in is zero; any nonzero tail is
  // still visible to rounding through the remainder sticky.
  always_comb begin
    vq     = '0;
    vq.sgn = sign_q;
    if (q[QBITS-1]) begin
      vq.scale    = scale_q;
      vq.fraction = q[QBITS-2:0];
    end else begin
      vq.scale    = scale_q - 9'sd1;
      vq.fraction = {q[QBITS-3:0], 1'b0};
    end
    vq.sticky = |rem;
  end

  posit_div_seq_round_pack u_round_pack (
    .vq    (vq),
    .posit (packed_q)
  );

  assign bus.busy = (state == DIVIDE) || (state == NORM_ROUND);
  assign bus.done = (state == DONE);

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the values from before the edge, matching hardware.
  // NOTE: only control and visible outputs are reset; the datapath
  // registers are always loaded at accept before they are read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bus.result <= '0;
      bus.inf    <= 1'b0;
      bus.zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q  <= a.sgn ^ b.sgn;
            scale_q <= a.scale - b.scale;
            rem     <= {1'b0, 1'b1, a.fraction};
            div     <= {1'b1, b.fraction};
            q       <= '0;
            cnt     <= '0;
            if (a.inf || b.inf || b.zero) begin
              bus.result <= NAR;
              bus.inf    <= 1'b1;
              bus.zero   <= 1'b0;
              state      <= DONE;
            end else if (a.zero) begin
              bus.result <= '0;
              bus.inf    <= 1'b0;
              bus.zero   <= 1'b1;
              state      <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_next;
          cnt <= cnt + 6'd1;
`ifdef POSIT_DIV_EARLY_TERM_EN
          if (rem_next == '0) begin
            // Every remaining quotient bit would be zero.
            q     <= q_next << (6'(QBITS - 1) - cnt);
            state <= NORM_ROUND;
          end else begin
            q <= q_next;
            if (cnt == 6'(QBITS - 1)) state <= NORM_ROUND;
          end
`else
          q <= q_next;
          if (cnt == 6'(QBITS - 1)) state <= NORM_ROUND;
`endif
        end
        NORM_ROUND: begin
          bus.result <= packed_q;
          bus.inf    <= 1'b0;
          bus.zero   <= 1'b0;
          state      <= DONE;
        end
        default: state <= IDLE;  // DONE: start is ignored here
      endcase
    end
  end

endmodule

// File: tb/tb_posit_div_seq.sv
// Directed self-checking bench for posit_div_seq: expected results are
// queued when an operation is issued and compared when done pulses.
module tb_posit_div_seq;
  import posit_div_seq_pkg::*;

`ifdef POSIT_DIV_EARLY_TERM_EN
  localparam int LAT_EXACT = 3;   // quotient significand exactly 1.0
`else
  localparam int LAT_EXACT = 34;
`endif
  localparam int LAT_FULL    = 34;
  localparam int LAT_SPECIAL = 1;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        inf;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  posit_div_seq_if bus();

  posit_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] res, input logic inf,
                          input logic zero, input int lat);
    exp_t e;
    e.tag  = tag;
    e.res  = res;
    e.inf  = inf;
    e.zero = zero;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Called at the negedge of cycle cyc0 after the accepting edge; waits
  // (bounded) for done, then scores the oldest queued expectation.
  task automatic await_and_score(input int cyc0);
    exp_t e;
    int   cyc;
    int   busy_cyc;
    logic [31:0] held;
    cyc      = cyc0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check({e.tag, " done"},      32'(bus.done), 32'd1);
    check({e.tag, " result"},    bus.result, e.res);
    check({e.tag, " inf"},       32'(bus.inf), 32'(e.inf));
    check({e.tag, " zero"},      32'(bus.zero), 32'(e.zero));
    check({e.tag, " latency"},   32'(cyc), 32'(e.lat));
    check({e.tag, " busy_cyc"},  32'(busy_cyc), 32'(e.lat - cyc0));
    check({e.tag, " busy@done"}, 32'(bus.busy), 32'd0);
    held = bus.result;
    @(negedge clk);
    check({e.tag, " done_pulse"}, 32'(bus.done), 32'd0);
    check({e.tag, " held"},       bus.result, held);
  endtask

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] res, input logic inf, input logic zero,
                       input int lat);
    push_exp(tag, res, inf, zero, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = x;
    bus.in2   = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in1   = $urandom;   // operands need only be valid at the accept edge
    bus.in2   = $urandom;
    await_and_score(1);
  endtask

  initial begin
    int done_seen;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(negedge clk);
    check("rst result", bus.result, 32'h0);
    check("rst inf",    32'(bus.inf),  32'd0);
    check("rst zero",   32'(bus.zero), 32'd0);
    check("rst done",   32'(bus.done), 32'd0);
    check("rst busy",   32'(bus.busy), 32'd0);
    reset = 1'b0;

    do_op("1/2",       32'h40000000, 32'h48000000, 32'h38000000, 1'b0, 1'b0, LAT_EXACT);
    do_op("3/1.5",     32'h4C000000, 32'h44000000, 32'h48000000, 1'b0, 1'b0, LAT_EXACT);
    do_op("1/3",       32'h40000000, 32'h4C000000, 32'h32AAAAAB, 1'b0, 1'b0, LAT_FULL);
    do_op("-1/2",      32'hC0000000, 32'h48000000, 32'hC8000000, 1'b0, 1'b0, LAT_EXACT);
    do_op("2/-1",      32'h48000000, 32'hC0000000, 32'hB8000000, 1'b0, 1'b0, LAT_EXACT);
    do_op("max/min",   32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, LAT_EXACT);
    do_op("min/max",   32'h00000001, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, LAT_EXACT);
    do_op("1/0",       32'h40000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, LAT_SPECIAL);
    do_op("0/2",       32'h00000000, 32'h48000000, 32'h00000000, 1'b0, 1'b1, LAT_SPECIAL);
    do_op("NaR/2",     32'h80000000, 32'h48000000, 32'h80000000, 1'b1, 1'b0, LAT_SPECIAL);
    do_op("0/0",       32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, LAT_SPECIAL);

    // Reset in the middle of 1/3: no done, busy drops, result cleared.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 32'h40000000;
    bus.in2   = 32'h4C000000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy",   32'(bus.busy), 32'd0);
    check("abort done",   32'(bus.done), 32'd0);
    check("abort result", bus.result, 32'h0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'd0);

    // 1/2 with a second start (3/1.5) issued while busy: ignored.
    push_exp("1/2 w/ 2nd start", 32'h38000000, 1'b0, 1'b0, LAT_EXACT);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 32'h40000000;
    bus.in2   = 32'h48000000;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("2nd start busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.in1   = 32'h4C000000;
    bus.in2   = 32'h44000000;
    @(negedge clk);
    bus.start = 1'b0;
    await_and_score(3);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    check("2nd start ignored", 32'(done_seen), 32'd0);
    check("2nd start result",  bus.result, 32'h38000000);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
